// File: rtl/aes256_loading_core.sv
// aes256_loading_core: iterative AES-256 encryptor. The master key is expanded
// into a 60-word round-key store, each block takes 14 rounds, and the
// ciphertext is streamed out one byte per cycle, most significant byte first.

// S-box: multiplicative inverse in GF(2^8) followed by the AES affine map.
module aes256_loading_core_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x12, x14, x15, x30, x60, x120, x240, inv;

  // Inverse as a^254 through a short addition chain (0 maps to 0), then affine.
  always_comb begin
    x2   = gf_mul(a_i, a_i);
    x3   = gf_mul(x2, a_i);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x14  = gf_mul(x12, x2);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    inv  = gf_mul(x240, x14);
    s_o  = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

module aes256_loading_core (
  input  logic         clk,
  input  logic         rst,
  input  logic         pi_key_expand_start,
  input  logic [255:0] pi_master_key,
  output logic         po_key_ready,
  input  logic         pi_next_val_req,
  input  logic [127:0] pi_data,
  output logic         po_next_val_ready,
  output logic [7:0]   po_data
);

  typedef enum logic [2:0] {IDLE, KEYEXP, READY, ENC, OUT} state_e;

  state_e       state_q, state_d;
  logic         key_ready_q, key_ready_d;
  logic         nv_q, nv_d;
  logic [7:0]   data_q, data_d;
  logic [5:0]   idx_q, idx_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [127:0] st_q, st_d;

  logic [31:0]  rk_q [60];
  logic         load_key;
  logic         rk_we;
  logic [31:0]  rk_wdata;

  logic [31:0]  kprev, ksub, ktemp;
  logic [7:0]   rcon;
  logic [5:0]   rk_base;
  logic [127:0] round_key, sb_w, sr, mc, round_out, final_out;
  logic [7:0]   a0, a1, a2, a3;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Single 16-byte SubBytes for the round datapath.
  for (genvar g = 0; g < 16; g++) begin : g_round_sbox
    aes256_loading_core_sbox u_sbox (
      .a_i (st_q[127-8*g -: 8]),
      .s_o (sb_w[127-8*g -: 8])
    );
  end

  // Single 4-byte SubWord for key expansion.
  for (genvar g = 0; g < 4; g++) begin : g_key_sbox
    aes256_loading_core_sbox u_sbox (
      .a_i (kprev[31-8*g -: 8]),
      .s_o (ksub[31-8*g -: 8])
    );
  end

  // Previous key word feeds SubWord.
  always_comb begin
    kprev = rk_q[idx_q - 6'd1];
  end

  // Next key word w[i] = w[i-8] ^ f(w[i-1]); SubWord(RotWord(w)) is taken as RotWord(SubWord(w)).
  always_comb begin
    case (idx_q[5:3])
      3'd1:    rcon = 8'h01;
      3'd2:    rcon = 8'h02;
      3'd3:    rcon = 8'h04;
      3'd4:    rcon = 8'h08;
      3'd5:    rcon = 8'h10;
      3'd6:    rcon = 8'h20;
      3'd7:    rcon = 8'h40;
      default: rcon = 8'h00;
    endcase
    case (idx_q[2:0])
      3'd0:    ktemp = {ksub[23:0], ksub[31:24]} ^ {rcon, 24'h000000};
      3'd4:    ktemp = ksub;
      default: ktemp = kprev;
    endcase
    rk_wdata = rk_q[idx_q - 6'd8] ^ ktemp;
  end

  // Round datapath: ShiftRows, MixColumns and AddRoundKey around the shared SubBytes.
  always_comb begin
    rk_base   = (state_q == ENC) ? {rnd_q, 2'b00} : 6'd0;
    round_key = {rk_q[rk_base], rk_q[rk_base + 6'd1], rk_q[rk_base + 6'd2], rk_q[rk_base + 6'd3]};
    sr = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        sr[127-8*(r+4*c) -: 8] = sb_w[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    mc = '0;
    a0 = '0;
    a1 = '0;
    a2 = '0;
    a3 = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = sr[127-32*c -: 8];
      a1 = sr[119-32*c -: 8];
      a2 = sr[111-32*c -: 8];
      a3 = sr[103-32*c -: 8];
      mc[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      mc[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      mc[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      mc[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    round_out = mc ^ round_key;
    final_out = sr ^ round_key;
  end

  // Control: next state, counters and output registers; a start pulse overrides everything.
  always_comb begin
    state_d     = state_q;
    key_ready_d = key_ready_q;
    nv_d        = nv_q;
    data_d      = data_q;
    idx_d       = idx_q;
    rnd_d       = rnd_q;
    cnt_d       = cnt_q;
    st_d        = st_q;
    load_key    = 1'b0;
    rk_we       = 1'b0;
    if (pi_key_expand_start) begin
      load_key    = 1'b1;
      idx_d       = 6'd8;
      state_d     = KEYEXP;
      key_ready_d = 1'b0;
      nv_d        = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        KEYEXP: begin
          if (idx_q == 6'd60) begin
            state_d     = READY;
            key_ready_d = 1'b1;
          end else begin
            rk_we = 1'b1;
            idx_d = idx_q + 6'd1;
          end
        end
        READY: begin
          if (pi_next_val_req) begin
            st_d    = pi_data ^ round_key;
            rnd_d   = 4'd1;
            state_d = ENC;
          end
        end
        ENC: begin
          if (rnd_q == 4'd14) begin
            st_d    = final_out;
            cnt_d   = '0;
            state_d = OUT;
          end else begin
            st_d  = round_out;
            rnd_d = rnd_q + 4'd1;
          end
        end
        OUT: begin
          if (cnt_q == 5'd16) begin
            nv_d    = 1'b0;
            state_d = READY;
          end else begin
            data_d = st_q[127:120];
            st_d   = {st_q[119:0], 8'h00};
            nv_d   = 1'b1;
            cnt_d  = cnt_q + 5'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      key_ready_q <= 1'b0;
      nv_q        <= 1'b0;
      data_q      <= '0;
      idx_q       <= '0;
      rnd_q       <= '0;
      cnt_q       <= '0;
      st_q        <= '0;
    end else begin
      state_q     <= state_d;
      key_ready_q <= key_ready_d;
      nv_q        <= nv_d;
      data_q      <= data_d;
      idx_q       <= idx_d;
      rnd_q       <= rnd_d;
      cnt_q       <= cnt_d;
      st_q        <= st_d;
    end
  end

  // Round-key store: master key loads w0..w7 at once, expansion writes one word per cycle.
  always_ff @(posedge clk) begin
    if (load_key) begin
      for (int unsigned i = 0; i < 8; i++) begin
        rk_q[i] <= pi_master_key[255-32*i -: 32];
      end
    end else if (rk_we) begin
      rk_q[idx_q] <= rk_wdata;
    end
  end

  assign po_key_ready      = key_ready_q;
  assign po_next_val_ready = nv_q;
  assign po_data           = data_q;

endmodule

// File: tb/tb_aes256_loading_core.sv
// tb_aes256_loading_core: known-answer table, randomized blocks against a
// byte-array AES-256 model, and hand sequences for re-key, reset and overlap cases.
`timescale 1ns/1ps

module tb_aes256_loading_core;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [255:0] key;
  logic         key_ready;
  logic         req;
  logic [127:0] data;
  logic         nv;
  logic [7:0]   po_data;

  always #5 clk = ~clk;

  aes256_loading_core dut (
    .clk                 (clk),
    .rst                 (rst),
    .pi_key_expand_start (start),
    .pi_master_key       (key),
    .po_key_ready        (key_ready),
    .pi_next_val_req     (req),
    .pi_data             (data),
    .po_next_val_ready   (nv),
    .po_data             (po_data)
  );

  int unsigned total  = 0;
  int unsigned bad    = 0;
  int unsigned strays = 0;

  logic [7:0]  sbox_t [256];
  logic [31:0] m_w [60];

  typedef struct {
    logic [255:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;
  vec_t vecs [3];

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    while (y != 8'h00) begin
      if (y[0]) p = p ^ x;
      x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return gmul(a, 8'h02);
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      for (int i = 0; i < 8; i++) begin
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      end
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  task automatic model_expand(input logic [255:0] k);
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 8; i++) m_w[i] = k[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = m_w[i-1];
      if (i % 8 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = xtime(rc);
      end else if (i % 8 == 4) begin
        t = sub_word(t);
      end
      m_w[i] = m_w[i-8] ^ t;
    end
  endtask

  function automatic logic [127:0] model_encrypt(input logic [127:0] pt);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   b0, b1, b2, b3;
    logic [31:0]  wd;
    logic [127:0] res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[127-8*(4*c+r) -: 8];
    for (int rnd = 0; rnd <= 14; rnd++) begin
      if (rnd > 0) begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            s[r][c] = sbox_t[s[r][c]];
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            t[r][c] = s[r][(c+r)%4];
        s = t;
        if (rnd < 14) begin
          for (int c = 0; c < 4; c++) begin
            b0 = s[0][c]; b1 = s[1][c]; b2 = s[2][c]; b3 = s[3][c];
            s[0][c] = gmul(b0, 8'h02) ^ gmul(b1, 8'h03) ^ b2 ^ b3;
            s[1][c] = b0 ^ gmul(b1, 8'h02) ^ gmul(b2, 8'h03) ^ b3;
            s[2][c] = b0 ^ b1 ^ gmul(b2, 8'h02) ^ gmul(b3, 8'h03);
            s[3][c] = gmul(b0, 8'h03) ^ b1 ^ b2 ^ gmul(b3, 8'h02);
          end
        end
      end
      for (int c = 0; c < 4; c++) begin
        wd = m_w[4*rnd+c];
        for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ wd[31-8*r -: 8];
      end
    end
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(4*c+r) -: 8] = s[r][c];
    return res;
  endfunction

  // ---------------- checkers ----------------
  task automatic chk_v(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic pulse_req(input logic [127:0] pt);
    data = pt; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      if (nv === 1'b1) strays++;
    end
  endtask

  task automatic collect(output logic [127:0] ct, output int unsigned n, output int unsigned last);
    ct = '0; n = 0; last = 0;
    for (int unsigned k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (nv === 1'b1) begin
        n++; last = k; ct = {ct[119:0], po_data};
      end else if (n != 0) begin
        break;
      end
    end
  endtask

  // Start an expansion (optionally with a simultaneous or later req) and wait for key_ready.
  task automatic rekey(input string tag, input logic [255:0] k, input bit with_req, input bit poke);
    int unsigned cyc, seen;
    model_expand(k);
    key = k; start = 1'b1; req = with_req; data = rnd128();
    @(negedge clk);
    start = 1'b0; req = 1'b0;
    chk_b({tag, " key_ready drop"}, key_ready, 1'b0);
    chk_b({tag, " ready drop"}, nv, 1'b0);
    cyc = 0; seen = 0;
    while (key_ready !== 1'b1 && cyc < 100) begin
      req = poke && (cyc == 3);
      @(negedge clk);
      cyc++;
      if (nv === 1'b1) seen++;
    end
    req = 1'b0;
    chk_b({tag, " key_ready within budget"}, key_ready, 1'b1);
    chk_i({tag, " no output during expansion"}, seen, 0);
  endtask

  task automatic enc_check(input string tag, input logic [127:0] pt, input logic [127:0] exp, input bit chk_lat);
    logic [127:0] ct;
    int unsigned  n, last;
    pulse_req(pt);
    collect(ct, n, last);
    chk_v({tag, " ciphertext"}, ct, exp);
    chk_i({tag, " ready count"}, n, 16);
    if (chk_lat) chk_i({tag, " last byte latency"}, last, 30);
  endtask

  task automatic watch_none(input string tag, input int unsigned cycles);
    int unsigned seen;
    seen = 0;
    for (int unsigned i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (nv === 1'b1) seen++;
    end
    chk_i({tag, " no output"}, seen, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] ct, pa, pb;
    logic [255:0] kr;
    int unsigned  n, last, s0, seen;

    vecs[0] = '{key: 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                pt:  128'h00112233445566778899aabbccddeeff,
                ct:  128'h8ea2b7ca516745bfeafc49904b496089};
    vecs[1] = '{key: 256'h0,
                pt:  128'h0,
                ct:  128'hdc95c078a2408989ad48a21492842087};
    vecs[2] = '{key: 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                pt:  128'h6bc1bee22e409f96e93d7e117393172a,
                ct:  128'hf3eed1bdb5d2a03c064b5a7e3db181f8};

    rst = 1'b1; start = 1'b0; req = 1'b0; key = '0; data = '0;
    build_sbox();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_b("reset key_ready", key_ready, 1'b0);
    chk_b("reset ready", nv, 1'b0);
    chk_v("reset data", {120'd0, po_data}, 128'h0);

    // Request with no key expanded.
    pulse_req(rnd128());
    watch_none("req before key", 100);
    chk_b("key_ready stays low", key_ready, 1'b0);

    // Known-answer table; the first entry also pokes a req during expansion.
    for (int i = 0; i < 3; i++) begin
      rekey($sformatf("kat%0d", i), vecs[i].key, 1'b0, (i == 0));
      enc_check($sformatf("kat%0d", i), vecs[i].pt, vecs[i].ct, 1'b1);
      chk_b($sformatf("kat%0d key_ready held", i), key_ready, 1'b1);
      idle(3);
    end

    // 1000 random blocks under one random key, 5-cycle gap.
    kr = rnd256();
    rekey("random key", kr, 1'b0, 1'b0);
    s0 = strays;
    for (int b = 0; b < 1000; b++) begin
      idle(4);
      pa = rnd128();
      pulse_req(pa);
      collect(ct, n, last);
      chk_v($sformatf("blk%0d ciphertext", b), ct, model_encrypt(pa));
      chk_i($sformatf("blk%0d ready count", b), n, 16);
    end
    chk_i("random run stray ready", strays - s0, 0);
    chk_b("random run key_ready held", key_ready, 1'b1);

    // Request issued on the first cycle back in READY.
    pa = rnd128(); pb = rnd128();
    enc_check("b2b first", pa, model_encrypt(pa), 1'b1);
    enc_check("b2b second", pb, model_encrypt(pb), 1'b1);

    // Request during ENC is ignored.
    pa = rnd128(); pb = rnd128();
    pulse_req(pa);
    idle(3);
    pulse_req(pb);
    collect(ct, n, last);
    chk_v("req in ENC ciphertext", ct, model_encrypt(pa));
    chk_i("req in ENC ready count", n, 16);
    watch_none("req in ENC follow-up", 60);

    // Start and req on the same edge: start wins.
    rekey("start+req", rnd256(), 1'b1, 1'b0);
    pa = rnd128();
    enc_check("start+req", pa, model_encrypt(pa), 1'b1);

    // Re-key while bytes are streaming out.
    pulse_req(rnd128());
    seen = 0;
    for (int unsigned k = 0; k < 100; k++) begin
      @(negedge clk);
      if (nv === 1'b1) begin
        seen++;
        if (seen == 3) break;
      end
    end
    chk_i("rekey reached OUT", seen, 3);
    rekey("rekey in OUT", rnd256(), 1'b0, 1'b0);
    enc_check("rekey C.3", vecs[0].pt, model_encrypt(vecs[0].pt), 1'b1);

    // Asynchronous reset during ENC.
    pulse_req(rnd128());
    idle(5);
    #1 rst = 1'b1;
    #1;
    chk_b("async rst key_ready", key_ready, 1'b0);
    chk_b("async rst ready", nv, 1'b0);
    chk_v("async rst data", {120'd0, po_data}, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    pulse_req(rnd128());
    watch_none("req after reset", 100);
    chk_b("key_ready after reset", key_ready, 1'b0);
    rekey("post reset", rnd256(), 1'b0, 1'b0);
    pa = rnd128();
    enc_check("post reset", pa, model_encrypt(pa), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/aes256_loading_core.md
Name: aes256_loading_core

Overview:
AES-256 encryption engine (FIPS-197) with a byte-serial ciphertext output. A 256-bit master key is expanded on request into an internal round-key store. Each requested 128-bit plaintext block is then encrypted iteratively, and the result is streamed out one byte per cycle, most significant byte first. The block sits between a key/data loader and a byte-wide downstream consumer.

Parameters:
None. Key size is fixed at 256 bits, block size at 128 bits, 14 rounds, and the output is fixed at 16 bytes.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
pi_key_expand_start  in  1  single-cycle pulse; starts expansion of pi_master_key
pi_master_key  in  256  master key, bit 255 = first key byte MSB; sampled on the start edge
po_key_ready  out  1  level; high when round keys are valid and the core accepts data
pi_next_val_req  in  1  single-cycle pulse; starts encryption of pi_data
pi_data  in  128  plaintext, bits 127:120 = byte 0; sampled on the req edge
po_next_val_ready  out  1  high exactly while po_data carries a valid ciphertext byte
po_data  out  8  ciphertext byte, registered

Behaviour:
- Reset values: po_key_ready=0, po_next_val_ready=0, po_data=0x00, FSM=IDLE, round-key store content is don't-care.
- FSM states are IDLE, KEYEXP, READY, ENC, OUT.
- IDLE, start edge:
  - Latch the key as words w0..w7 and go to KEYEXP.
  - Start is honoured from any state. It aborts any encryption/output in progress and drops po_key_ready and po_next_val_ready on the next edge.
- KEYEXP:
  - Generate one word per cycle for w8..w59, using standard RotWord/SubWord/Rcon for i%8==0 and SubWord only for i%8==4.
  - po_key_ready rises on the edge after w59 is written, which is no later than 60 cycles after the start edge (budget 100).
  - po_key_ready stays high until the next start pulse or reset.
- READY, req edge (E0):
  - Capture the state as pi_data XOR round key 0 and go to ENC.
  - A req received while not in READY (IDLE, KEYEXP, ENC, OUT) is ignored.
- ENC:
  - Edges E1..E13 each apply one full round: SubBytes, ShiftRows, MixColumns, AddRoundKey(rk r).
  - Edge E14 applies the final round without MixColumns, using rk14.
- OUT:
  - Edges E15..E30 each register one ciphertext byte to po_data with po_next_val_ready=1. The first byte is ciphertext[127:120] and the last is [7:0].
  - po_next_val_ready is high for exactly 16 consecutive cycles and is never high otherwise.
  - Edge E31 sets po_next_val_ready=0, holds po_data at its last value, and returns to READY.
  - Total latency from the req edge to the last byte is 30 cycles (budget 100).
- Back-to-back requests: a new req is accepted from the first cycle the FSM is back in READY.
- Round keys persist across any number of encryptions until a new expansion starts.
- S-box may be a 256-entry ROM or GF(2^8)-inverse logic. Exactly one 16-byte SubBytes instance is used for rounds and one 4-byte instance for key expansion.
- Mid-operation reset: all outputs return to reset values immediately, and a new expansion is required before data is accepted.
- pi_key_expand_start and pi_next_val_req on the same edge: start wins and req is ignored.

Test Plan:
1. Reset -> po_key_ready=0, po_next_val_ready=0, po_data=0x00. A req pulse with no key expanded -> no output bytes for 100 cycles.
2. Key expansion:
   - Stimulus: key 000102…1e1f, pulse start.
   - Required: po_key_ready=1 within 100 cycles and stays high.
3. Single encryption (FIPS-197 C.3):
   - Stimulus: plaintext 00112233445566778899aabbccddeeff, one req pulse.
   - Required: 16 consecutive ready cycles carrying 8e a2 b7 ca 51 67 45 bf ea fc 49 90 4b 49 60 89, then ready=0.
4. Back-to-back blocks:
   - Stimulus: 1000 random plaintexts under one random key, each req issued 5 cycles after the previous block's last byte.
   - Required: every byte matches the software model, and ready is asserted exactly 16 times per block.
5. Re-key:
   - Stimulus: pulse start during OUT with a new key.
   - Required: ready drops on the next edge and po_key_ready drops. After po_key_ready re-asserts, a C.3 encryption under the new key matches the model.
6. Async reset asserted mid-ENC:
   - Required: outputs clear without waiting for a clock edge, and a req after release produces no output until a new expansion completes.
